// File: rtl/switch_sampler_pkg.sv
// rtl/switch_sampler_pkg.sv - defaults and sizing helpers for the switch sampler
package switch_sampler_pkg;

`include "switch_defs.vh"

    localparam int SW_NUM_SW_DEF          = `SW_NUM_SW_DEFAULT;
    localparam int SW_DEBOUNCE_CYCLES_DEF = `SW_DEBOUNCE_CYCLES_DEFAULT;
    localparam int SW_FIFO_DEPTH_DEF      = `SW_FIFO_DEPTH_DEFAULT;

    // Debounce counter only ever reaches cycles-1, so clog2(cycles) bits suffice.
    function automatic int sw_cnt_w(input int cycles);
        return (`SW_CNT_W(cycles) < 1) ? 1 : `SW_CNT_W(cycles);
    endfunction

    function automatic int sw_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/switch_defs.vh
// rtl/switch_defs.vh - shared default sizing for the switch sampler
`ifndef SWITCH_DEFS_VH
`define SWITCH_DEFS_VH

`define SW_NUM_SW_DEFAULT          4
`define SW_DEBOUNCE_CYCLES_DEFAULT 16
`define SW_FIFO_DEPTH_DEFAULT      4
`define SW_CNT_W(cycles)           $clog2(cycles)

`endif

// File: rtl/switch_evt_fifo.sv
// rtl/switch_evt_fifo.sv - change-event queue; full/empty derived from an occupancy count
module switch_evt_fifo
    import switch_sampler_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = SW_FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_valid,
    output logic             o_drop
);

    localparam int AW = sw_ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    // A pop on the same edge frees the slot, so a full queue still accepts.
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_drop  = i_push && w_full && !w_pop;

    assign o_valid = !w_empty;
    assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/switch_sampler.sv
// rtl/switch_sampler.sv - synchronizes and debounces slide switches, queues change events
module switch_sampler
    import switch_sampler_pkg::*;
#(
    parameter int NUM_SW          = SW_NUM_SW_DEF,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEF,
    parameter int FIFO_DEPTH      = SW_FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] SlideSwitch,
    output logic [NUM_SW-1:0] sw_stable,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [NUM_SW-1:0] evt_data,
    output logic [NUM_SW-1:0] evt_mask,
    output logic              evt_ovf,
    input  logic              ovf_clr
);

    localparam int               CNT_W    = sw_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_SW-1:0] r_sync1;
    logic [NUM_SW-1:0] r_sync2;
    logic [NUM_SW-1:0] r_stable;
    logic [CNT_W-1:0]  r_cnt [NUM_SW];
    logic              r_ovf;

    logic [NUM_SW-1:0]   w_diff;
    logic [NUM_SW-1:0]   w_accept;
    logic [NUM_SW-1:0]   w_stable_nxt;
    logic [2*NUM_SW-1:0] w_rdata;
    logic                w_pop;
    logic                w_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= SlideSwitch;
            r_sync2 <= r_sync1;
        end
    end

    assign w_diff = r_sync2 ^ r_stable;

    always_comb begin
        w_accept = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            w_accept[i] = w_diff[i] && (r_cnt[i] == CNT_LAST);
        end
    end

    assign w_stable_nxt = r_stable ^ w_accept;

    // Counter restarts on any return to the stable level, so only an unbroken run is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SW; i++) begin
                r_cnt[i] <= '0;
            end
            r_stable <= '0;
        end else begin
            for (int i = 0; i < NUM_SW; i++) begin
                if (!w_diff[i] || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
            r_stable <= w_stable_nxt;
        end
    end

    assign w_pop = evt_valid && evt_ready;

    switch_evt_fifo #(
        .WIDTH (2 * NUM_SW),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (|w_accept),
        .i_wdata ({w_stable_nxt, w_accept}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_valid (evt_valid),
        .o_drop  (w_drop)
    );

    // A drop on the clearing edge must stay visible, so it takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign sw_stable = r_stable;
    assign evt_data  = w_rdata[2*NUM_SW-1:NUM_SW];
    assign evt_mask  = w_rdata[NUM_SW-1:0];
    assign evt_ovf   = r_ovf;

endmodule

// File: doc/switch_sampler.md
SWITCH_SAMPLER -- requirements
Module: switch_sampler

Interface
REQ-001 Parameter NUM_SW, default 4, shall set the number of slide-switch inputs.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, range 2..65535, shall set the consecutive clk cycles a changed input must persist before it is accepted.
REQ-003 Parameter FIFO_DEPTH, default 4, power of two, shall set the change-event queue depth.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 SlideSwitch  input  NUM_SW  raw asynchronous switch levels.
REQ-007 sw_stable  output  NUM_SW  debounced switch levels, for the LED driver.
REQ-008 evt_valid  output  1  change event available at queue head.
REQ-009 evt_ready  input  1  consumer accepts the head event.
REQ-010 evt_data  output  NUM_SW  sw_stable value after the change.
REQ-011 evt_mask  output  NUM_SW  bits that changed in that event.
REQ-012 evt_ovf  output  1  sticky: an event was dropped.
REQ-013 ovf_clr  input  1  synchronous clear of evt_ovf.

Function
REQ-014 Each SlideSwitch bit shall pass through a two-flop synchronizer before any other use.
REQ-015 Each bit shall own a counter that clears whenever the synchronized bit equals its sw_stable bit and increments while they differ.
REQ-016 When a counter is at DEBOUNCE_CYCLES-1 and the bit still differs, sw_stable for that bit shall toggle at that edge and the counter shall clear.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles shall not change sw_stable.
REQ-018 Bits accepted on the same edge shall form one event: evt_data = new sw_stable, evt_mask = toggled bits.
REQ-019 An event shall be pushed on the same edge sw_stable updates; evt_valid shall be high in the following cycle, i.e. DEBOUNCE_CYCLES+2 cycles after a clean input step.
REQ-020 A transfer shall occur on any edge with evt_valid and evt_ready both high; evt_data/evt_mask shall hold stable while evt_valid is high and evt_ready low.
REQ-021 Events shall leave in push order; evt_valid low shall mean queue empty.
REQ-022 Push into a full queue with no simultaneous pop shall drop the new event and set evt_ovf; sw_stable still updates.
REQ-023 Simultaneous push and pop when full shall succeed with no drop.
REQ-024 ovf_clr shall clear evt_ovf; a drop on the same edge shall win (evt_ovf stays 1).

Reset
REQ-025 rst_n low shall immediately clear synchronizers, counters, sw_stable, queue pointers, evt_valid, evt_data, evt_mask and evt_ovf to 0.
REQ-026 Reset mid-debounce or with events queued shall discard all pending state; switches high at release shall each yield an event after the normal debounce latency.

Structure
REQ-027 NUM_SW default, DEBOUNCE_CYCLES default, FIFO_DEPTH default and counter width (clog2) shall live in shared include switch_defs.vh.
REQ-028 The event queue shall be sub-module switch_evt_fifo (width 2*NUM_SW, depth FIFO_DEPTH, full/empty by count register); synchronizer and debounce shall be inline.

Verification (DEBOUNCE_CYCLES=16, FIFO_DEPTH=4)
REQ-029 Reset, SlideSwitch 0000->0101 step, evt_ready=1 -> sw_stable=0101 and evt_valid pulse 18 cycles after step, evt_data=0101, evt_mask=0101.
REQ-030 Bit0 high 10 cycles then low -> sw_stable, evt_valid never change.
REQ-031 evt_ready=0, five distinct clean toggles spaced 40 cycles -> four events queued, evt_ovf=1; then evt_ready=1 drains exactly four in order.
REQ-032 Queue full, push and pop on same edge -> no drop, evt_ovf unchanged; ovf_clr with simultaneous drop -> evt_ovf stays 1.
REQ-033 rst_n low at cycle 10 of a debounce with two events queued -> all outputs 0 asynchronously; SlideSwitch=1111 at release -> one event data=1111 mask=1111 after 18 cycles.
